// File: rtl/hv_gen_sequencer_if.sv
// HV generator sequencer bus: upstream launch, generator stream, encoder tags.
// master = sequencer side, slave = surrounding fabric / testbench.
interface hv_gen_sequencer_if #(
  parameter int CH_W = 7
);
  logic            fin_valid;
  logic            fin_ready;
  logic            gen_fin_valid;
  logic            gen_fin_ready;
  logic            gen_valid;
  logic            gen_ready;
  logic            enc_valid;
  logic            enc_ready;
  logic [1:0]      mod_id;
  logic [CH_W-1:0] chan_idx;
  logic            first_chan;
  logic            last_chan;
  logic            last_mod;
  logic            sample_done;
  logic [2:0]      inflight;
  logic            busy;
  logic            err_underflow;
  logic [15:0]     stall_cycles;

  modport master (
    input  fin_valid, gen_fin_ready, gen_valid,
    input  enc_ready, sample_done,
    output fin_ready, gen_fin_valid, gen_ready,
    output enc_valid, mod_id, chan_idx,
    output first_chan, last_chan, last_mod,
    output inflight, busy, err_underflow,
    output stall_cycles
  );

  modport slave (
    output fin_valid, gen_fin_ready, gen_valid,
    output enc_ready, sample_done,
    input  fin_ready, gen_fin_valid, gen_ready,
    input  enc_valid, mod_id, chan_idx,
    input  first_chan, last_chan, last_mod,
    input  inflight, busy, err_underflow,
    input  stall_cycles
  );
endinterface

// File: rtl/hv_gen_sequencer.sv
// HV generator sequencer: launches samples, tags GSR/ECG/EEG beats, limits
// in-flight samples. Ports: clk, rst (sync, high), bus (master modport).
// HV_SEQ_PERF_EN builds the stall_cycles counter; else it reads 0.
module hv_gen_sequencer #(
  parameter int GSR_NUM_CH   = 32,
  parameter int ECG_NUM_CH   = 77,
  parameter int EEG_NUM_CH   = 105,
  parameter int CH_W         = 7,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic clk,
  input  logic rst,
  hv_gen_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, GSR, ECG, EEG
  } state_t;

  localparam logic [CH_W-1:0] GSR_LAST = CH_W'(GSR_NUM_CH - 1);
  localparam logic [CH_W-1:0] ECG_LAST = CH_W'(ECG_NUM_CH - 1);
  localparam logic [CH_W-1:0] EEG_LAST = CH_W'(EEG_NUM_CH - 1);
  localparam logic [2:0]      MAX_IF   = 3'(MAX_INFLIGHT);

  state_t          state, state_nx;
  logic [CH_W-1:0] chan_q, chan_nx;
  logic [2:0]      infl_q, infl_nx;
  logic            err_q, err_nx;
  logic [1:0]      mod;
  logic [CH_W-1:0] lim;
  logic            idle, can_launch, launch;
  logic            beat, last_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      chan_q <= '0;
      infl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      chan_q <= chan_nx;
      infl_q <= infl_nx;
      err_q  <= err_nx;
    end
  end

  // Modality is a pure decode of the streaming state.
  always_comb begin
    mod = 2'd0;
    lim = GSR_LAST;
    unique case (state)
      ECG: begin
        mod = 2'd1;
        lim = ECG_LAST;
      end
      EEG: begin
        mod = 2'd2;
        lim = EEG_LAST;
      end
      default: begin
        mod = 2'd0;
        lim = GSR_LAST;
      end
    endcase
  end

  assign idle       = (state == IDLE);
  assign can_launch = idle && (infl_q < MAX_IF);
  assign launch     = bus.fin_valid && can_launch
                      && bus.gen_fin_ready;
  assign beat       = bus.gen_valid && !idle
                      && bus.enc_ready;
  assign last_c     = (chan_q == lim);

  always_comb begin
    state_nx = state;
    chan_nx  = chan_q;
    infl_nx  = infl_q;
    err_nx   = err_q;
    if (launch) begin
      state_nx = GSR;
      chan_nx  = '0;
    end else if (beat) begin
      if (last_c) begin
        chan_nx = '0;
        unique case (state)
          GSR:     state_nx = ECG;
          ECG:     state_nx = EEG;
          default: state_nx = IDLE;
        endcase
      end else begin
        chan_nx = chan_q + 1'b1;
      end
    end
    // A retire coinciding with a launch leaves the count unchanged.
    if (launch && !bus.sample_done) begin
      infl_nx = infl_q + 1'b1;
    end else if (!launch && bus.sample_done) begin
      if (infl_q != 3'd0) infl_nx = infl_q - 1'b1;
      else                err_nx  = 1'b1;
    end
  end

  assign bus.fin_ready     = bus.gen_fin_ready && can_launch;
  assign bus.gen_fin_valid = bus.fin_valid && can_launch;
  assign bus.enc_valid     = bus.gen_valid && !idle;
  assign bus.gen_ready     = bus.enc_ready && !idle;
  assign bus.mod_id        = mod;
  assign bus.chan_idx      = chan_q;
  assign bus.first_chan    = (chan_q == '0);
  assign bus.last_chan     = last_c;
  assign bus.last_mod      = last_c && (mod == 2'd2);
  assign bus.inflight      = infl_q;
  assign bus.busy          = !idle;
  assign bus.err_underflow = err_q;

`ifdef HV_SEQ_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (launch) begin
      stall_q <= '0;
    end else if (!idle && bus.gen_valid
                 && !bus.enc_ready
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule
